// File: rtl/hs_pkg.sv
// Shared definitions for the handshake transmit arbiter: FSM encoding and
// the default word width of the full-handshake transmitter.
package hs_pkg;

  localparam int HS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACCEPT = 2'd1,
    WAIT_DONE   = 2'd2
  } hsState_e;

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational round-robin picker: the first set request bit scanning upward
// from iPtr+1, wrapping modulo NUM_REQ.
module hs_rr_pick #(
  parameter  int NUM_REQ   = 4,
  localparam int GID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   iReq,
  input  logic [GID_WIDTH-1:0] iPtr,
  output logic                 oAny,
  output logic [GID_WIDTH-1:0] oWinner
);

  int idx;

  // Scan from farthest to nearest so the candidate closest to iPtr+1 is the
  // one that gets assigned last.
  always_comb begin
    oAny    = |iReq;
    oWinner = '0;
    idx     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(iPtr) + i) % NUM_REQ;
      if (iReq[idx[GID_WIDTH-1:0]]) begin
        oWinner = idx[GID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_tx_arbiter.sv
// Round-robin scheduler sharing one full-handshake transmitter between
// NUM_REQ requesters; all outputs come straight from registers.
module hs_tx_arbiter
  import hs_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = HS_DATA_WIDTH,
  parameter  int CNT_WIDTH  = 16,
  localparam int GID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          iTxClk,
  input  logic                          iRstnTx,
  input  logic                          iEnable,
  input  logic [NUM_REQ-1:0]            iReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
  output logic [NUM_REQ-1:0]            oReqAck,
  output logic [NUM_REQ-1:0]            oReqDone,
  input  logic                          iTxRdy,
  output logic                          oDataValid,
  output logic [DATA_WIDTH-1:0]         oData,
  output logic [GID_WIDTH-1:0]          oGrantId,
  output logic                          oBusy,
  output logic [CNT_WIDTH-1:0]          oXferCnt,
  output logic [1:0]                    oFsmState
);

  hsState_e             state;
  logic [GID_WIDTH-1:0] rrPtr;
  logic                 anyReq;
  logic [GID_WIDTH-1:0] winner;
  logic [DATA_WIDTH-1:0] reqWord [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqWord[i] = iReqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  hs_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .iReq    (iReqValid),
    .iPtr    (rrPtr),
    .oAny    (anyReq),
    .oWinner (winner)
  );

  // Four-phase handshake: oDataValid is raised with oData and held until
  // iTxRdy rises (word accepted); the transfer is complete when iTxRdy falls
  // again (receiver acknowledged). Valid stays low while waiting for that fall.
  always_ff @(posedge iTxClk) begin
    if (!iRstnTx) begin
      state      <= IDLE;
      rrPtr      <= GID_WIDTH'(NUM_REQ - 1);
      oDataValid <= 1'b0;
      oData      <= '0;
      oReqAck    <= '0;
      oReqDone   <= '0;
      oGrantId   <= '0;
      oBusy      <= 1'b0;
      oXferCnt   <= '0;
    end else begin
      oReqAck  <= '0;
      oReqDone <= '0;
      case (state)
        IDLE: begin
          if (iEnable && anyReq) begin
            oData           <= reqWord[winner];
            oGrantId        <= winner;
            oReqAck[winner] <= 1'b1;
            oDataValid      <= 1'b1;
            oBusy           <= 1'b1;
            state           <= WAIT_ACCEPT;
          end
        end
        WAIT_ACCEPT: begin
          if (iTxRdy) begin
            oDataValid <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!iTxRdy) begin
            oReqDone[oGrantId] <= 1'b1;
            oXferCnt           <= oXferCnt + 1'b1;
            rrPtr              <= oGrantId;
            oBusy              <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          oDataValid <= 1'b0;
          oBusy      <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign oFsmState = state;

endmodule

// File: doc/hs_tx_arbiter.md
Name: hs_tx_arbiter

Overview:
Round-robin scheduler that shares one full-handshake transmitter between NUM_REQ local requesters in the Tx clock domain.
- Grants one requester at a time and captures its word.
- Presents the word to the transmitter's valid/data inputs.
- Sequences the transfer using the transmitter's ready output: ready rise means the word is accepted; ready fall means the receiver acknowledged.
- Returns a per-requester done pulse when the transfer completes.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
DATA_WIDTH, 32, word width; equals the transmitter's DATA_WIDTH
CNT_WIDTH, 16, width of completed-transfer counter
GID_WIDTH, $clog2(NUM_REQ), grant index width (derived localparam)

Ports:
iTxClk  in  1  Tx-domain clock; all logic on posedge
iRstnTx  in  1  synchronous active-low reset, sampled on posedge iTxClk
iEnable  in  1  1 = new grants allowed; 0 = finish current transfer, then hold in IDLE
iReqValid  in  NUM_REQ  per-requester request; held until matching oReqAck
iReqData  in  NUM_REQ*DATA_WIDTH  requester i's word on bits [i*DATA_WIDTH +: DATA_WIDTH]
oReqAck  out  NUM_REQ  one-cycle pulse: word captured; requester may drop or change its request
oReqDone  out  NUM_REQ  one-cycle pulse: receiver acknowledged this requester's word
iTxRdy  in  1  transmitter ready output
oDataValid  out  1  to transmitter valid input
oData  out  DATA_WIDTH  to transmitter data input
oGrantId  out  GID_WIDTH  index of the current or last granted requester
oBusy  out  1  1 when state != IDLE
oXferCnt  out  CNT_WIDTH  completed transfers, wraps modulo 2^CNT_WIDTH

Behaviour:
- All outputs are registered.
- Reset (iRstnTx=0 at a clock edge), from any state:
  - state=IDLE; oDataValid=0, oData=0, oReqAck=0, oReqDone=0, oGrantId=0, oXferCnt=0, oBusy=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
  - An in-flight transfer is dropped with no oReqDone. The system ties the transmitter's reset to the same source.
- State IDLE:
  - Condition: iEnable=1 and |iReqValid.
  - Winner: first set bit scanning upward from pointer+1, wrapping modulo NUM_REQ.
  - Next edge: oData<=winner's word, oGrantId<=winner, oReqAck[winner]<=1 for one cycle, oDataValid<=1, go to WAIT_ACCEPT.
- State WAIT_ACCEPT:
  - oDataValid and oData are held.
  - When iTxRdy=1: oDataValid<=0, go to WAIT_DONE.
  - The transmitter may still be completing a previous four-phase cycle. Valid is held until ready rises, so the word is never lost.
- State WAIT_DONE:
  - When iTxRdy=0: oReqDone[oGrantId]<=1 for one cycle, oXferCnt<=oXferCnt+1, pointer<=oGrantId, go to IDLE.
- Latency:
  - Request visible in cycle 0 (IDLE) → oReqAck and oDataValid high in cycle 1.
  - Transmitter ready high in cycle 2 → oDataValid low in cycle 3.
  - oReqDone fires 1 cycle after ready is seen low.
  - Minimum 1 IDLE cycle between transfers.
- Valid is never asserted in WAIT_DONE, so each transfer produces exactly one ready rise.
- iEnable:
  - Sampled only in IDLE.
  - Deasserting it mid-transfer does not abort; the block returns to IDLE and waits.
- iReqValid dropped before grant: no ack is issued and no state changes. Requests are level-sensitive and not latched.
- A request arriving in the same cycle as oReqDone is arbitrated in the following IDLE cycle against the updated pointer.
- Only one oReqAck bit and one oReqDone bit are ever set; they are never high in the same cycle.
- oData holds the last word after completion. It is not cleared until the next grant or reset.

Decomposition:
- Shared package hs_pkg: state encoding localparams (IDLE=0, WAIT_ACCEPT=1, WAIT_DONE=2, 2-bit) and the handshake DATA_WIDTH default.
- One sub-module, hs_rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: any-request flag, winner index.
  - Parameterised by NUM_REQ.

Test Plan:
1. Single request: iReqValid=4'b0100, word 32'hA5A5_0001; transmitter model (ready 1 cycle after valid, ack after 3 cycles) → oReqAck[2] in cycle 1, oData=32'hA5A5_0001, one oReqDone[2], oXferCnt=1.
2. All four requesting continuously, data 0x10..0x13 → grant order 0,1,2,3,0; oData sequence 0x10,0x11,0x12,0x13,0x10; never two acks in one cycle.
3. Fairness: requester 0 re-requests immediately after each done; requester 3 requests once → requester 3 is granted no later than the 4th transfer.
4. iEnable dropped during WAIT_ACCEPT with 3 requests pending → current transfer completes with oReqDone; block stays IDLE (oBusy=0) until iEnable=1; next grant follows the round-robin pointer.
5. Reset asserted in WAIT_DONE → next edge: all outputs zero, no oReqDone; after release, a request to requester 1 completes normally.
6. CNT_WIDTH=4 override, 17 transfers → oXferCnt reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
